// File: rtl/control_pipeline.sv
// Control-side pipeline: ID/EX, EX/MEM, MEM/WB control registers,
// hazard detection, stall/flush generation and forwarding selects.
module control_pipeline #(
  parameter int CONTROL_SIZE = 8,
  parameter int REG_W        = 5,
  parameter int RA_ADDR      = 31,
  parameter int CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CONTROL_SIZE-1:0] idControl,
  input  logic [1:0]              idBranchSrc,
  input  logic [1:0]              idCompareCode,
  input  logic                    idTaken,
  input  logic [REG_W-1:0]        idRs,
  input  logic [REG_W-1:0]        idRt,
  input  logic [REG_W-1:0]        idRd,
  output logic [CONTROL_SIZE-1:0] exControl,
  output logic [REG_W-1:0]        exRs,
  output logic [REG_W-1:0]        exRt,
  output logic [REG_W-1:0]        exDest,
  output logic [4:0]              memControl,
  output logic [REG_W-1:0]        memDest,
  output logic [2:0]              wbControl,
  output logic [REG_W-1:0]        wbDest,
  output logic                    pcWrite,
  output logic                    ifidWrite,
  output logic                    ifidFlush,
  output logic [1:0]              forwardA,
  output logic [1:0]              forwardB,
  output logic                    idForwardA,
  output logic                    idForwardB,
  output logic [CNT_W-1:0]        stallCount
);

  logic [REG_W-1:0] idDest;
  logic exWr, memWr, wbWr, memLoad;
  logic useRs, useRt;
  logic loadUse, branchHaz, stall;

  always_comb begin
    idDest = '0;
    unique case (idControl[6:5])
      2'd0:    idDest = idRd;
      2'd1:    idDest = idRt;
      2'd2:    idDest = REG_W'(RA_ADDR);
      default: idDest = '0;
    endcase
  end

  // dest 0 or RegWrite=0 never counts as a writer
  assign exWr    = exControl[2] && (exDest != '0);
  assign memWr   = memControl[2] && (memDest != '0);
  assign wbWr    = wbControl[2] && (wbDest != '0);
  assign memLoad = memWr && memControl[4];

  assign useRt = (idCompareCode == 2'b01) || (idCompareCode == 2'b10);
  assign useRs = useRt ||
                 ((idCompareCode == 2'b11) && (idBranchSrc == 2'b10));

  assign loadUse = exWr && exControl[4] &&
                   ((exDest == idRs) || (exDest == idRt));

  assign branchHaz =
    (useRs && ((exWr && exDest == idRs) ||
               (memLoad && memDest == idRs))) ||
    (useRt && ((exWr && exDest == idRt) ||
               (memLoad && memDest == idRt)));

  assign stall     = loadUse || branchHaz;
  assign pcWrite   = !stall;
  assign ifidWrite = !stall;
  assign ifidFlush = reset && idTaken && !stall;

  assign idForwardA = !stall && useRs && memWr &&
                      !memControl[4] && (memDest == idRs);
  assign idForwardB = !stall && useRt && memWr &&
                      !memControl[4] && (memDest == idRt);

  always_comb begin
    forwardA = 2'b00;
    if (memWr && memDest == exRs)
      forwardA = 2'b10;
    else if (wbWr && wbDest == exRs)
      forwardA = 2'b01;
  end

  always_comb begin
    forwardB = 2'b00;
    if (memWr && memDest == exRt)
      forwardB = 2'b10;
    else if (wbWr && wbDest == exRt)
      forwardB = 2'b01;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exControl  <= '0;
      exRs       <= '0;
      exRt       <= '0;
      exDest     <= '0;
      memControl <= '0;
      memDest    <= '0;
      wbControl  <= '0;
      wbDest     <= '0;
      stallCount <= '0;
    end else begin
      if (stall) begin
        exControl <= '0;
        exRs      <= '0;
        exRt      <= '0;
        exDest    <= '0;
      end else begin
        exControl <= idControl;
        exRs      <= idRs;
        exRt      <= idRt;
        exDest    <= idDest;
      end
      memControl <= exControl[4:0];
      memDest    <= exDest;
      wbControl  <= memControl[2:0];
      wbDest     <= memDest;
      if (stall && stallCount != {CNT_W{1'b1}})
        stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: directed scenarios plus random
// instruction streams against a stage-array reference model.
module tb_control_pipeline;

  logic       clock = 0;
  logic       reset = 0;
  logic [7:0] idControl = 0;
  logic [1:0] idBranchSrc = 0;
  logic [1:0] idCompareCode = 0;
  logic       idTaken = 0;
  logic [4:0] idRs = 0, idRt = 0, idRd = 0;
  logic [7:0] exControl;
  logic [4:0] exRs, exRt, exDest;
  logic [4:0] memControl;
  logic [4:0] memDest;
  logic [2:0] wbControl;
  logic [4:0] wbDest;
  logic       pcWrite, ifidWrite, ifidFlush;
  logic [1:0] forwardA, forwardB;
  logic       idForwardA, idForwardB;
  logic [15:0] stallCount;

  int nchecks = 0;
  int nerrors = 0;

  control_pipeline dut (
    .clock(clock), .reset(reset),
    .idControl(idControl), .idBranchSrc(idBranchSrc),
    .idCompareCode(idCompareCode), .idTaken(idTaken),
    .idRs(idRs), .idRt(idRt), .idRd(idRd),
    .exControl(exControl), .exRs(exRs), .exRt(exRt),
    .exDest(exDest), .memControl(memControl),
    .memDest(memDest), .wbControl(wbControl),
    .wbDest(wbDest), .pcWrite(pcWrite),
    .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .forwardA(forwardA), .forwardB(forwardB),
    .idForwardA(idForwardA), .idForwardB(idForwardB),
    .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: stage records indexed 0=EX, 1=MEM, 2=WB
  logic [7:0] st_ctl [3];
  logic [4:0] st_dst [3];
  logic [4:0] ex_rs, ex_rt;
  int         m_cnt;
  bit         m_stall;

  function automatic bit writes(int s, logic [4:0] r);
    return st_ctl[s][2] && st_dst[s] != 0 && st_dst[s] == r;
  endfunction

  function automatic bit loads(int s, logic [4:0] r);
    return writes(s, r) && st_ctl[s][4];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      st_ctl[s] = 0;
      st_dst[s] = 0;
    end
    ex_rs = 0;
    ex_rt = 0;
    m_cnt = 0;
    m_stall = 0;
  endtask

  function automatic logic [1:0] fsel(logic [4:0] r);
    if (writes(1, r)) return 2'b10;
    if (writes(2, r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_check();
    bit ur, ut, lu, bh, st, fa, fb;
    ut = idCompareCode inside {2'b01, 2'b10};
    ur = ut || (idCompareCode == 2'b11 && idBranchSrc == 2'b10);
    lu = loads(0, idRs) || loads(0, idRt);
    bh = (ur && (writes(0, idRs) || loads(1, idRs))) ||
         (ut && (writes(0, idRt) || loads(1, idRt)));
    st = lu || bh;
    fa = !st && ur && writes(1, idRs) && !st_ctl[1][4];
    fb = !st && ut && writes(1, idRt) && !st_ctl[1][4];
    m_stall = st;
    check("exControl", exControl, st_ctl[0]);
    check("exRs", exRs, ex_rs);
    check("exRt", exRt, ex_rt);
    check("exDest", exDest, st_dst[0]);
    check("memControl", memControl, st_ctl[1][4:0]);
    check("memDest", memDest, st_dst[1]);
    check("wbControl", wbControl, st_ctl[2][2:0]);
    check("wbDest", wbDest, st_dst[2]);
    check("pcWrite", pcWrite, !st);
    check("ifidWrite", ifidWrite, !st);
    check("ifidFlush", ifidFlush, reset && idTaken && !st);
    check("forwardA", forwardA, fsel(ex_rs));
    check("forwardB", forwardB, fsel(ex_rt));
    check("idForwardA", idForwardA, fa);
    check("idForwardB", idForwardB, fb);
    check("stallCount", stallCount, m_cnt);
  endtask

  task automatic model_step();
    logic [4:0] dsel [4];
    dsel = '{idRd, idRt, 5'd31, 5'd0};
    st_ctl[2] = st_ctl[1] & 8'h07;
    st_dst[2] = st_dst[1];
    st_ctl[1] = st_ctl[0] & 8'h1f;
    st_dst[1] = st_dst[0];
    st_ctl[0] = m_stall ? 8'h00 : idControl;
    st_dst[0] = m_stall ? 5'd0 : dsel[idControl[6:5]];
    ex_rs = m_stall ? 5'd0 : idRs;
    ex_rt = m_stall ? 5'd0 : idRt;
    if (m_stall && m_cnt < 65535) m_cnt++;
  endtask

  task automatic cyc(input logic [7:0] c, input logic [1:0] b,
                     input logic [1:0] cc, input logic t,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd);
    @(posedge clock);
    #1;
    idControl = c;
    idBranchSrc = b;
    idCompareCode = cc;
    idTaken = t;
    idRs = rs;
    idRt = rt;
    idRd = rd;
    @(negedge clock);
    model_check();
    model_step();
  endtask

  task automatic nop();
    cyc(8'h00, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  localparam logic [7:0] ADD  = 8'h04;
  localparam logic [7:0] ADDI = 8'hA4;
  localparam logic [7:0] LW   = 8'hB5;
  localparam logic [7:0] JAL  = 8'hC4;
  localparam logic [7:0] RD3W = 8'h64;

  initial begin
    model_reset();
    #12;
    check("rst_exControl", exControl, 8'h00);
    check("rst_pcWrite", pcWrite, 1'b1);
    check("rst_stallCount", stallCount, 16'd0);
    @(negedge clock);
    reset = 1;

    // reset mid-stall
    cyc(8'b01101010, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3);
    cyc(LW, 2'd0, 2'd0, 1'b0, 5'd0, 5'd8, 5'd0);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd8, 5'd1, 5'd3);
    check("midstall_pcWrite", pcWrite, 1'b0);
    #1 reset = 0;
    #1;
    model_reset();
    check("inrst_exControl", exControl, 8'h00);
    check("inrst_memControl", memControl, 5'd0);
    check("inrst_pcWrite", pcWrite, 1'b1);
    model_check();
    idControl = 0; idRs = 0; idRt = 0; idRd = 0;
    @(negedge clock);
    reset = 1;
    nop();
    check("postrst_pcWrite", pcWrite, 1'b1);

    // load-use
    cyc(LW, 2'd0, 2'd0, 1'b0, 5'd0, 5'd8, 5'd0);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd8, 5'd1, 5'd3);
    check("lu_pcWrite", pcWrite, 1'b0);
    check("lu_ifidWrite", ifidWrite, 1'b0);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd8, 5'd1, 5'd3);
    check("lu_release", pcWrite, 1'b1);
    check("lu_bubble", exControl, 8'h00);
    check("lu_count", stallCount, 16'd1);
    nop();
    check("lu_fwdA_wb", forwardA, 2'b01);

    // EX forwarding
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd5);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd6);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd5, 5'd6, 5'd7);
    nop();
    check("fwd_A_wb", forwardA, 2'b01);
    check("fwd_B_mem", forwardB, 2'b10);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd5);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd5);
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd5, 5'd6, 5'd7);
    nop();
    check("fwd_A_prio", forwardA, 2'b10);

    // branch operand hazards; taken during stall is held off
    cyc(ADDI, 2'd0, 2'd0, 1'b0, 5'd1, 5'd9, 5'd0);
    cyc(8'h00, 2'd0, 2'd1, 1'b1, 5'd9, 5'd0, 5'd0);
    check("br_alu_stall", pcWrite, 1'b0);
    check("br_taken_held", ifidFlush, 1'b0);
    cyc(8'h00, 2'd0, 2'd1, 1'b0, 5'd9, 5'd0, 5'd0);
    check("br_alu_go", pcWrite, 1'b1);
    check("br_idfwdA", idForwardA, 1'b1);
    cyc(LW, 2'd0, 2'd0, 1'b0, 5'd1, 5'd9, 5'd0);
    cyc(8'h00, 2'd0, 2'd1, 1'b0, 5'd9, 5'd0, 5'd0);
    check("br_lw_stall1", pcWrite, 1'b0);
    cyc(8'h00, 2'd0, 2'd1, 1'b0, 5'd9, 5'd0, 5'd0);
    check("br_lw_stall2", pcWrite, 1'b0);
    cyc(8'h00, 2'd0, 2'd1, 1'b0, 5'd9, 5'd0, 5'd0);
    check("br_lw_go", pcWrite, 1'b1);
    check("br_lw_nofwd", idForwardA, 1'b0);

    // jal
    cyc(JAL, 2'd0, 2'd3, 1'b1, 5'd0, 5'd0, 5'd0);
    check("jal_nostall", pcWrite, 1'b1);
    check("jal_flush", ifidFlush, 1'b1);
    nop();
    check("jal_flush_off", ifidFlush, 1'b0);
    check("jal_exDest", exDest, 5'd31);
    nop();
    nop();
    check("jal_wbDest", wbDest, 5'd31);

    // register 0 never hazards or forwards
    cyc(ADD, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd0);
    cyc(RD3W, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd4);
    cyc(8'h00, 2'd0, 2'd1, 1'b0, 5'd0, 5'd0, 5'd0);
    check("r0_nostall", pcWrite, 1'b1);
    check("r0_noidfwd", idForwardA, 1'b0);
    nop();
    check("r0_fwdA", forwardA, 2'b00);
    check("r0_fwdB", forwardB, 2'b00);

    // random stream; a stalled instruction stays in ID
    for (int i = 0; i < 600; i++) begin
      if (m_stall)
        cyc(idControl, idBranchSrc, idCompareCode, idTaken,
            idRs, idRt, idRd);
      else
        cyc(8'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
